// File: rtl/fetch_aligner.sv
// Instruction-fetch realigner: buffers up to three halfwords and hands out whole
// 16/32-bit instructions. Optional macro FETCH_ILLEGAL_DET_EN adds out_illegal.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
`ifdef FETCH_ILLEGAL_DET_EN
  output logic        out_illegal,
`endif
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam logic [31:0] NOP = 32'h0000_0033;

  typedef enum logic [1:0] {S_RST, S_RUN, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] hw_q [3];
  logic [15:0] hw_d [3];
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic        drop_q, drop_d;
  logic        skip_lo_q, skip_lo_d;

  logic        is32, avail, fire, accept, resp, ins;
  logic [1:0]  cons;
  logic [2:0]  cnt_rem, n_ins, cnt_sum;

  // Output decode looks only at registered buffer state.
  assign is32      = (hw_q[0][1:0] == 2'b11);
  assign avail     = is32 ? (cnt_q >= 2'd2) : (cnt_q != 2'd0);
  assign out_valid = avail && !redirect;
  assign out_inst  = !out_valid ? NOP : (is32 ? {hw_q[1], hw_q[0]} : {16'h0000, hw_q[0]});
  assign out_pc    = pc_q;

`ifdef FETCH_ILLEGAL_DET_EN
  assign out_illegal = out_valid && !is32 && (hw_q[0] == 16'h0000);
`endif

  // Redirect suppresses the request so the first fetch uses the new target.
  assign mem_req  = (state_q == S_RUN) && !pending_q && (cnt_q <= 2'd1) && !redirect;
  assign mem_addr = fetch_addr_q;
  assign fire     = out_valid && out_ready;
  assign accept   = mem_req;
  assign resp     = mem_valid && pending_q;
  assign ins      = resp && !drop_q && !redirect;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    drop_d       = drop_q;
    skip_lo_d    = skip_lo_q;
    cons         = 2'd0;
    n_ins        = 3'd0;
    for (int i = 0; i < 3; i++) hw_d[i] = hw_q[i];

    if (fire) cons = is32 ? 2'd2 : 2'd1;
    case (cons)
      2'd1: begin
        hw_d[0] = hw_q[1];
        hw_d[1] = hw_q[2];
        hw_d[2] = 16'h0000;
      end
      2'd2: begin
        hw_d[0] = hw_q[2];
        hw_d[1] = 16'h0000;
        hw_d[2] = 16'h0000;
      end
      default: ;
    endcase
    cnt_rem = {1'b0, cnt_q} - {1'b0, cons};

    // Append behind whatever survives the consume in the same cycle.
    if (ins) begin
      n_ins = skip_lo_q ? 3'd1 : 3'd2;
      for (int i = 0; i < 3; i++) begin
        if (skip_lo_q) begin
          if (3'(i) == cnt_rem) hw_d[i] = mem_rdata[31:16];
        end else begin
          if (3'(i) == cnt_rem) hw_d[i] = mem_rdata[15:0];
          else if (3'(i) == cnt_rem + 3'd1) hw_d[i] = mem_rdata[31:16];
        end
      end
    end
    cnt_sum = cnt_rem + n_ins;
    cnt_d   = cnt_sum[1:0];

    if (fire) pc_d = pc_q + (is32 ? 32'd4 : 32'd2);
    if (accept) begin
      pending_d    = 1'b1;
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
    if (resp) begin
      pending_d = 1'b0;
      drop_d    = 1'b0;
    end
    if (ins && skip_lo_q) skip_lo_d = 1'b0;

    case (state_q)
      S_RST:   state_d = S_RUN;
      S_DRAIN: if (mem_valid) state_d = S_RUN;
      default: ;
    endcase

    if (redirect) begin
      cnt_d        = 2'd0;
      pc_d         = redirect_pc & 32'hFFFF_FFFE;
      fetch_addr_d = redirect_pc & 32'hFFFF_FFFC;
      skip_lo_d    = redirect_pc[1];
      if (pending_q && !mem_valid) begin
        drop_d  = 1'b1;
        state_d = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RST;
      cnt_q        <= 2'd0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      drop_q       <= 1'b0;
      skip_lo_q    <= RESET_PC[1];
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      skip_lo_q    <= skip_lo_d;
    end
  end

  // Halfword slots are qualified by cnt_q, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) hw_q[i] <= hw_d[i];
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: a halfword-stream model fills the expected
// queue on every (re)start; a negedge monitor pops and compares each handshake.
module tb_fetch_aligner;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_ILLEGAL_DET_EN
  logic        out_illegal;
`endif

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
`ifdef FETCH_ILLEGAL_DET_EN
    .out_illegal(out_illegal),
`endif
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit [31:0]   mem [bit [31:0]];
  exp_t        q[$];
  bit          resp_pending = 0;
  bit [31:0]   resp_addr;
  int          resp_cnt = 0;
  int          cur_lat = 1;
  int          acc_count = 0;
  int          outs_seen = 0;
  bit          acc8 = 0;
  bit          redir_after8 = 0;
  bit          chk_fetch = 0;
  bit [31:0]   exp_fetch;
  bit          prev_stall = 0;
  logic [31:0] prev_inst, prev_pc;

  function automatic bit [31:0] mem_word(bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic bit [15:0] hw_at(bit [31:0] a);
    bit [31:0] w;
    w = mem_word(a & 32'hFFFF_FFFC);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Walk the instruction stream from a new start PC.
  function automatic void restart(bit [31:0] target);
    bit [31:0] p;
    bit [15:0] h;
    exp_t      e;
    q.delete();
    p = target & 32'hFFFF_FFFE;
    for (int k = 0; k < 512; k++) begin
      h = hw_at(p);
      e.pc = p;
      if (h[1:0] == 2'b11) begin
        e.inst = {hw_at(p + 32'd2), h};
        p = p + 32'd4;
      end else begin
        e.inst = {16'h0000, h};
        p = p + 32'd2;
      end
      q.push_back(e);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit redir, input bit [31:0] rpc, input bit rdy);
    @(posedge clk);
    #1;
    if (redir_after8 && acc8) begin
      redir = 1'b1;
      rpc = 32'h0000_0200;
      redir_after8 = 0;
    end
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    mem_valid   = 1'b0;
    mem_rdata   = $urandom;
    if (resp_pending) begin
      if (resp_cnt == 0) begin
        mem_valid    = 1'b1;
        mem_rdata    = mem_word(resp_addr);
        resp_pending = 0;
      end else begin
        resp_cnt--;
      end
    end
    if (redir) begin
      restart(rpc);
      exp_fetch = rpc & 32'hFFFF_FFFC;
      chk_fetch = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    mem_valid = 1'b0;
    out_ready = 1'b0;
    resp_pending = 0;
    chk_fetch = 0;
    q.delete();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_out_inst", out_inst, 32'h0000_0033);
    check("rst_out_pc", out_pc, 32'h0000_0000);
    check("rst_mem_addr", mem_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    restart(32'h0);
    exp_fetch = 32'h0;
    chk_fetch = 1;
    @(negedge clk);
    check("rst_exit_no_fetch", mem_req, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && !redirect) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_inst", out_inst, prev_inst);
        check("stall_pc", out_pc, prev_pc);
      end
      if (mem_req) begin
        check("addr_align", mem_addr[1:0], 2'b00);
        if (resp_pending || mem_valid) begin
          n_tests++;
          n_fail++;
          $display("FAIL one_outstanding: request at %h while response owed for %h", mem_addr, resp_addr);
        end
        if (chk_fetch) begin
          check("first_fetch_addr", mem_addr, exp_fetch);
          chk_fetch = 0;
        end
        resp_pending = 1;
        resp_addr = mem_addr;
        resp_cnt = cur_lat - 1;
        acc_count++;
        if (mem_addr == 32'h8) acc8 = 1;
      end
      if (out_valid && out_ready) begin
        outs_seen++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_output: got inst %h pc %h, none expected", out_inst, out_pc);
        end else begin
          e = q.pop_front();
          check("out_inst", out_inst, e.inst);
          check("out_pc", out_pc, e.pc);
        end
      end
`ifdef FETCH_ILLEGAL_DET_EN
      check("out_illegal", out_illegal, out_valid && (out_inst == 32'h0));
`endif
      prev_stall = out_valid && !out_ready;
      prev_inst = out_inst;
      prev_pc = out_pc;
    end
  end

  initial begin
    bit [15:0] h0, h1;
    bit [31:0] rpc;
    int k;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_valid = 1'b0;
    mem_rdata = '0; out_ready = 1'b0;
    #2;

    // Two aligned 32-bit words.
    mem.delete(); mem[32'h0] = 32'h0000_0013; mem[32'h4] = 32'h0000_0013;
    do_reset();
    repeat (20) step(0, 0, 1);

    // Two compressed in one word.
    mem.delete(); mem[32'h0] = 32'h4501_4581;
    do_reset();
    repeat (20) step(0, 0, 1);

    // 32-bit instruction straddling a word boundary.
    mem.delete(); mem[32'h0] = 32'h0513_4581; mem[32'h4] = 32'h1234_0000;
    do_reset();
    repeat (20) step(0, 0, 1);

    // Redirect to an odd-halfword target.
    mem.delete(); mem[32'h100] = 32'h4505_ABCD;
    do_reset();
    step(1, 32'h0000_0102, 1);
    repeat (20) step(0, 0, 1);

    // Redirect while a slow fetch of 0x8 is in flight.
    mem.delete();
    do_reset();
    cur_lat = 3;
    acc8 = 0;
    redir_after8 = 1;
    k = 0;
    while (redir_after8 && k < 80) begin
      step(0, 0, 1);
      k++;
    end
    check("drain_redirect_issued", redir_after8, 1'b0);
    repeat (30) step(0, 0, 1);
    cur_lat = 1;

    // Stall with a compressed-only stream.
    mem.delete();
    for (int a = 0; a < 64; a++) begin
      h0 = 16'($urandom); h1 = 16'($urandom);
      if (h0[1:0] == 2'b11) h0[1:0] = 2'b01;
      if (h1[1:0] == 2'b11) h1[1:0] = 2'b10;
      mem[32'(a * 4)] = {h1, h0};
    end
    do_reset();
    repeat (6) step(0, 0, 1);
    acc_count = 0;
    repeat (10) step(0, 0, 0);
    @(negedge clk);
    check("stall_fetch_count_ok", acc_count <= 2, 1'b1);
    check("stall_req_stopped", mem_req, 1'b0);
    repeat (40) step(0, 0, 1);

    // Randomised traffic, redirects and a mid-run reset.
    mem.delete();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      cur_lat = $urandom_range(1, 4);
      if (c == 600) do_reset();
      if ($urandom_range(0, 99) < 4) begin
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2);
        else rpc = 32'($urandom_range(0, 1023) * 2);
        rpc = rpc | 32'($urandom_range(0, 1));
        step(1, rpc, $urandom_range(0, 3) != 0);
      end else begin
        step(0, 0, $urandom_range(0, 3) != 0);
      end
    end
    step(0, 0, 1);
    @(negedge clk);
    check("enough_outputs", outs_seen >= 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch realignment stage sitting directly upstream of the decompression unit.
- Fetches word-aligned 32-bit words from instruction memory and keeps a 3-halfword buffer.
- Presents one whole instruction per handshake: either a 16-bit compressed instruction or a 32-bit instruction, including 32-bit instructions that straddle a word boundary.
- Also tracks the halfword-granular PC and handles control-flow redirects, including redirects to odd-halfword targets.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset; must be halfword aligned (bit 0 = 0).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
mem_req  out  1  fetch request; accepted by memory in the same cycle it is high.
mem_addr  out  32  word-aligned fetch address (bits [1:0] = 00).
mem_rdata  in  32  returned instruction word.
mem_valid  in  1  mem_rdata valid; arrives at least 1 cycle after acceptance.
redirect  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  32  new PC; bit 0 ignored (treated as 0).
out_valid  out  1  out_inst/out_pc valid.
out_ready  in  1  downstream accepts the instruction.
out_inst  out  32  instruction to decompression unit.
out_pc  out  32  PC of out_inst.

Behaviour:
- Buffer: 3 halfword slots hw0..hw2 (hw0 oldest) plus cnt (0..3).
- Other state: fetch_addr (word aligned), pc, pending (request outstanding), drop (discard next response), skip_lo (discard low halfword of next response).
- FSM states:
  - S_RST: entered while rst=0. One cycle after release, go to S_RUN with no fetch issued.
  - S_RUN: normal operation.
  - S_DRAIN: a redirect occurred while pending=1. Wait for mem_valid, discard that word, then go to S_RUN.
- Reset values:
  - out_valid=0, mem_req=0, out_inst=32'h0000_0033 (nop), out_pc=RESET_PC, mem_addr={RESET_PC[31:2],2'b00}.
  - cnt=0, pending=0, drop=0, skip_lo=RESET_PC[1].
- Fetch:
  - mem_req=1 in S_RUN when pending=0 and cnt<=1; mem_addr=fetch_addr.
  - On acceptance: pending<=1, fetch_addr<=fetch_addr+4.
  - At most one request outstanding, ever.
- Insert: on mem_valid with pending=1 and not dropping:
  - Append {hi,lo} halfwords, or only hi if skip_lo=1 (then clear skip_lo).
  - pending<=0.
  - cnt never exceeds 3.
- Output (combinational from registered state only; no path from mem_rdata):
  - Compressed: cnt>=1 and hw0[1:0]!=2'b11 -> out_valid=1, out_inst={16'h0000,hw0}.
  - 32-bit: cnt>=2 and hw0[1:0]==2'b11 -> out_valid=1, out_inst={hw1,hw0}.
  - Otherwise out_valid=0 and out_inst=nop.
  - out_pc=pc.
- Consume: on out_valid && out_ready:
  - Shift buffer by 1 (compressed) or 2 (32-bit).
  - pc <= pc+2 or pc+4.
- Simultaneous insert and consume: cnt_next = cnt - consumed + inserted; shift and append happen in the same cycle.
- Stall: with out_ready=0, out_inst/out_pc stay stable; fetching stops once cnt reaches 2 or 3.
- Redirect (highest priority; overrides consume and insert in that cycle):
  - cnt<=0, pc<=redirect_pc&~1, fetch_addr<={redirect_pc[31:2],2'b00}, skip_lo<=redirect_pc[1].
  - out_valid is forced 0 in the redirect cycle.
  - If pending=1 and mem_valid=0: drop<=1, go to S_DRAIN.
  - If mem_valid arrives in the same cycle as the redirect, the word is discarded and pending is cleared.
  - A new fetch issues the cycle after the redirect (or after the drain completes).
  - A second redirect during S_DRAIN updates the target; the drain still completes.
- Wrap-around: pc and fetch_addr wrap modulo 2^32 without special handling.
- rst assertion mid-operation: immediate return to reset values; any in-flight response after release is ignored because pending=0.

Optional Feature:
- Macro: FETCH_ILLEGAL_DET_EN.
- Defined: adds output out_illegal (1 bit, reset 0). It is 1 when out_valid=1, the instruction is compressed, and hw0==16'h0000 (defined-illegal compressed encoding). The instruction is still presented and consumed normally.
- Undefined: the port is absent and there is no detection logic.

Test Plan:
1. Reset release with RESET_PC=0; mem word@0=32'h0000_0013, @4=32'h0000_0013 -> mem_addr 0 then 4; out_inst 0x00000013 at out_pc 0, then at out_pc 4.
2. Word@0=32'h4501_4581 -> out_inst 0x00004581 pc 0, then 0x00004501 pc 2; each pc advances by 2.
3. Straddle: word@0=32'h0513_4581, word@4=32'h1234_0000 -> 0x00004581 pc 0; then 0x00000513 pc 2, presented only after word@4 returns; hw 0x1234 stays buffered.
4. redirect=1, redirect_pc=0x102; word@0x100=32'h4505_ABCD -> mem_addr 0x100, low half dropped, first out_inst 0x00004505 pc 0x102.
5. Redirect to 0x200 issued 1 cycle after a fetch@0x8 is accepted, with response 3 cycles later -> that response discarded, no new mem_req until it arrives; first output comes from 0x200.
6. out_ready=0 for 10 cycles with a compressed stream -> out_inst/out_pc constant, mem_req stops once cnt>=2, no data lost; after release all instructions appear in order with pc +2 steps.
